// File: rtl/ram_access_seq.sv
// ram_access_seq
//   Upstream access sequencer for the 2-bit serial RAM. A read or write request
//   accepted over valid/ready is turned into a serial bit frame on the RAM pins:
//   one command bit, the address MSB first, then the data MSB first. Read data
//   comes back on ram_rd during the data phase. The result, or a write ack, is
//   returned over a response handshake. A wrapping program counter supplies
//   the address for sequential accesses.
//
//   Optional feature macro: RAM_SEQ_PARITY_EN
//     defined   : a parity cycle follows the data phase. A write drives the
//                 wdata parity. A read samples the RAM parity bit and flags
//                 rsp_perr when it disagrees with the received data.
//     undefined : no parity cycle, and rsp_perr is tied to 0.
//
// Ports
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready   request handshake; req_ready is combinational
//   req_we, req_seq       write select; use pc_out as the address, then advance pc
//   req_addr, req_wdata   explicit address (req_seq=0), write data
//   rsp_valid/rsp_ready   response handshake; the response holds until consumed
//   rsp_rdata, rsp_perr   read data (0 for writes), parity error flag
//   pc_out                program counter
//   ram_status, ram_a0    frame-active (low) and bit strobe (high) pins
//   ram_b0, ram_rd        serial bit to the RAM, serial read bit from the RAM
module ram_access_seq #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_seq,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_perr,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ram_status,
    output logic              ram_a0,
    output logic              ram_b0,
    input  logic              ram_rd
);

`ifdef RAM_SEQ_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int SH_W  = ADDR_W + DATA_W + PAR_W;
    localparam int MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(MAX_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DATA,
`ifdef RAM_SEQ_PARITY_EN
        S_PAR,
`endif
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-1:0]     shift_q, shift_d;
    logic                we_q, we_d;
    logic                seq_q, seq_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic                ram_status_q, ram_status_d;
    logic                ram_a0_q, ram_a0_d;
    logic                ram_b0_q, ram_b0_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
`ifdef RAM_SEQ_PARITY_EN
    logic                rsp_perr_q, rsp_perr_d;
`endif

    logic [ADDR_W-1:0]   addr_sel;
    logic [DATA_W-1:0]   wdata_sel;
    logic [SH_W-1:0]     shift_load;
    logic [DATA_W-1:0]   rdata_in;

    // The bits sent after the command bit are queued in one shift register at
    // acceptance time. Every later frame cycle simply pops its MSB. Read
    // frames queue zeros in the data and parity slots.
    always_comb begin
        addr_sel  = req_seq ? pc_q : req_addr;
        wdata_sel = req_we ? req_wdata : '0;
`ifdef RAM_SEQ_PARITY_EN
        shift_load = {addr_sel, wdata_sel, (req_we & ^req_wdata)};
`else
        shift_load = {addr_sel, wdata_sel};
`endif
        rdata_in  = DATA_W'({rdata_q, ram_rd});
    end

    // Next-state and next-output logic. The pins are registered, so each
    // state arm computes the pin values for the cycle that follows.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        we_d         = we_q;
        seq_d        = seq_q;
        rdata_d      = rdata_q;
        pc_d         = pc_q;
        ram_status_d = ram_status_q;
        ram_a0_d     = ram_a0_q;
        ram_b0_d     = ram_b0_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
`ifdef RAM_SEQ_PARITY_EN
        rsp_perr_d   = rsp_perr_q;
`endif
        req_ready    = (state_q == S_IDLE) && !rsp_valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    state_d      = S_CMD;
                    cnt_d        = '0;
                    shift_d      = shift_load;
                    we_d         = req_we;
                    seq_d        = req_seq;
                    rdata_d      = '0;
                    ram_status_d = 1'b0;
                    ram_a0_d     = 1'b1;
                    ram_b0_d     = req_we;
                end
            end
            S_CMD: begin
                state_d  = S_ADDR;
                cnt_d    = '0;
                ram_b0_d = shift_q[SH_W-1];
                shift_d  = shift_q << 1;
            end
            S_ADDR: begin
                ram_b0_d = shift_q[SH_W-1];
                shift_d  = shift_q << 1;
                if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                rdata_d = rdata_in;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
`ifdef RAM_SEQ_PARITY_EN
                    state_d  = S_PAR;
                    ram_b0_d = shift_q[SH_W-1];
                    shift_d  = shift_q << 1;
`else
                    // Last frame cycle: return the pins to idle and present
                    // the response.
                    state_d      = S_RESP;
                    ram_status_d = 1'b1;
                    ram_a0_d     = 1'b0;
                    ram_b0_d     = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = we_q ? '0 : rdata_in;
`endif
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    ram_b0_d = shift_q[SH_W-1];
                    shift_d  = shift_q << 1;
                end
            end
`ifdef RAM_SEQ_PARITY_EN
            S_PAR: begin
                state_d      = S_RESP;
                ram_status_d = 1'b1;
                ram_a0_d     = 1'b0;
                ram_b0_d     = 1'b0;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = we_q ? '0 : rdata_q;
                rsp_perr_d   = !we_q && (ram_rd != ^rdata_q);
            end
`endif
            S_RESP: begin
                // The pc only advances once the response is consumed, so a
                // stalled sequential read still reports its own address.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                    if (seq_q) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any frame in progress and
    // drops the pins to their idle values at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            shift_q      <= '0;
            we_q         <= 1'b0;
            seq_q        <= 1'b0;
            rdata_q      <= '0;
            pc_q         <= '0;
            ram_status_q <= 1'b1;
            ram_a0_q     <= 1'b0;
            ram_b0_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
`ifdef RAM_SEQ_PARITY_EN
            rsp_perr_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            we_q         <= we_d;
            seq_q        <= seq_d;
            rdata_q      <= rdata_d;
            pc_q         <= pc_d;
            ram_status_q <= ram_status_d;
            ram_a0_q     <= ram_a0_d;
            ram_b0_q     <= ram_b0_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
`ifdef RAM_SEQ_PARITY_EN
            rsp_perr_q   <= rsp_perr_d;
`endif
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign pc_out     = pc_q;
    assign ram_status = ram_status_q;
    assign ram_a0     = ram_a0_q;
    assign ram_b0     = ram_b0_q;
`ifdef RAM_SEQ_PARITY_EN
    assign rsp_perr   = rsp_perr_q;
`else
    assign rsp_perr   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_seq.sv
// tb_ram_access_seq
//   Drives ram_access_seq with a table of directed transactions, then with
//   randomized transactions checked against a simple memory and pc model.
//   It finishes with hand-written sequences for reset and backpressure.
//   The bench plays the RAM: it feeds ram_rd from its own memory array.
module tb_ram_access_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic       req_seq;
    logic [1:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_rdata;
    logic       rsp_perr;
    logic [1:0] pc_out;
    logic       ram_status;
    logic       ram_a0;
    logic       ram_b0;
    logic       ram_rd;

    int total = 0;
    int bad   = 0;

    logic [1:0] model_pc;
    logic [1:0] mem [4];

    typedef struct {
        logic       we;
        logic       seq;
        logic [1:0] addr;
        logic [1:0] wdata;
        logic [1:0] rd_bits;
        logic [4:0] exp_frame;
        logic [1:0] exp_rdata;
        logic [1:0] exp_pc;
        int         hold;
    } vec_t;

    vec_t vecs [9];

    ram_access_seq #(.ADDR_W(2), .DATA_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_seq    (req_seq),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_perr   (rsp_perr),
        .pc_out     (pc_out),
        .ram_status (ram_status),
        .ram_a0     (ram_a0),
        .ram_b0     (ram_b0),
        .ram_rd     (ram_rd)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete transaction, starting and ending at posedge+1 with the
    // sequencer idle. The request fields are scrambled right after acceptance,
    // so the frame must come from the captured copy.
    task automatic applyStimulus(input logic we, input logic seq, input logic [1:0] addr,
                                 input logic [1:0] wdata, input logic [1:0] rd_bits,
                                 input logic [4:0] exp_frame, input logic [1:0] exp_rdata,
                                 input logic [1:0] exp_pc, input int hold);
        req_valid = 1'b1;
        req_we    = we;
        req_seq   = seq;
        req_addr  = addr;
        req_wdata = wdata;
        rsp_ready = 1'b0;
        checkOutput("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'($urandom);
        req_we    = 1'($urandom);
        req_seq   = 1'($urandom);
        req_addr  = 2'($urandom);
        req_wdata = 2'($urandom);
        for (int k = 0; k < 5; k++) begin
            checkOutput("frame_status", ram_status, 0);
            checkOutput("frame_a0", ram_a0, 1);
            checkOutput($sformatf("frame_b0[%0d]", k), ram_b0, exp_frame[4-k]);
            checkOutput("frame_req_ready", req_ready, 0);
            checkOutput("frame_rsp_valid", rsp_valid, 0);
            ram_rd = (k >= 3) ? rd_bits[4-k] : 1'($urandom);
            @(posedge clk); #1;
        end
        ram_rd = 1'($urandom);
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("end_status", ram_status, 1);
        checkOutput("end_a0", ram_a0, 0);
        checkOutput("end_b0", ram_b0, 0);
        checkOutput("rsp_rdata", rsp_rdata, exp_rdata);
        checkOutput("rsp_perr", rsp_perr, 0);
        checkOutput("rsp_req_ready", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1;
            rsp_ready = 1'b0;
            @(posedge clk); #1;
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_rdata", rsp_rdata, exp_rdata);
            checkOutput("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checkOutput("post_rsp_valid", rsp_valid, 0);
        checkOutput("post_req_ready", req_ready, 1);
        checkOutput("post_pc", pc_out, exp_pc);
        checkOutput("post_status", ram_status, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        logic       we, seq;
        logic [1:0] addr, wdata, a, rd, exp_rd;
        logic [4:0] frame;

        // we seq addr wdata rd_bits frame rdata pc hold
        vecs[0] = '{1'b1, 1'b0, 2'd2, 2'd1, 2'd0, 5'b11001, 2'd0, 2'd0, 0};
        vecs[1] = '{1'b0, 1'b0, 2'd1, 2'd3, 2'd2, 5'b00100, 2'd2, 2'd0, 0};
        vecs[2] = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd3, 5'b00000, 2'd3, 2'd1, 0};
        vecs[3] = '{1'b0, 1'b1, 2'd3, 2'd0, 2'd1, 5'b00100, 2'd1, 2'd2, 1};
        vecs[4] = '{1'b0, 1'b1, 2'd0, 2'd2, 2'd2, 5'b01000, 2'd2, 2'd3, 0};
        vecs[5] = '{1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 5'b01100, 2'd0, 2'd0, 2};
        vecs[6] = '{1'b0, 1'b1, 2'd2, 2'd0, 2'd3, 5'b00000, 2'd3, 2'd1, 0};
        vecs[7] = '{1'b1, 1'b0, 2'd3, 2'd2, 2'd0, 5'b11110, 2'd0, 2'd1, 3};
        vecs[8] = '{1'b1, 1'b1, 2'd0, 2'd3, 2'd1, 5'b10111, 2'd0, 2'd2, 0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_seq = 1'b0;
        req_addr = 2'd0; req_wdata = 2'd0; rsp_ready = 1'b0; ram_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_status", ram_status, 1);
        checkOutput("rst_a0", ram_a0, 0);
        checkOutput("rst_b0", ram_b0, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_pc", pc_out, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_req_ready", req_ready, 1);

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].seq, vecs[i].addr, vecs[i].wdata, vecs[i].rd_bits,
                          vecs[i].exp_frame, vecs[i].exp_rdata, vecs[i].exp_pc, vecs[i].hold);
        end

        // Randomized phase against the memory and pc model.
        model_pc = 2'd2;
        for (int j = 0; j < 4; j++) mem[j] = 2'd0;
        for (int n = 0; n < 40; n++) begin
            we     = 1'($urandom);
            seq    = 1'($urandom);
            addr   = 2'($urandom);
            wdata  = 2'($urandom);
            a      = seq ? model_pc : addr;
            frame  = {we, a, (we ? wdata : 2'd0)};
            rd     = mem[a];
            exp_rd = we ? 2'd0 : mem[a];
            if (we) mem[a] = wdata;
            if (seq) model_pc = model_pc + 2'd1;
            applyStimulus(we, seq, addr, wdata, rd, frame, exp_rd, model_pc,
                          int'($urandom_range(0, 2)));
        end

        // Reset during the second data cycle of a sequential read.
        if (model_pc == 2'd0) begin
            applyStimulus(1'b0, 1'b1, 2'd0, 2'd0, 2'd1, 5'b00000, 2'd1, 2'd1, 0);
            model_pc = 2'd1;
        end
        req_valid = 1'b1; req_we = 1'b0; req_seq = 1'b1; req_addr = 2'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid_status_before_rst", ram_status, 0);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_status", ram_status, 1);
        checkOutput("mid_rst_a0", ram_a0, 0);
        checkOutput("mid_rst_b0", ram_b0, 0);
        checkOutput("mid_rst_rsp_valid", rsp_valid, 0);
        checkOutput("mid_rst_pc", pc_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checkOutput("after_rst_rsp_valid", rsp_valid, 0);
        checkOutput("after_rst_req_ready", req_ready, 1);
        checkOutput("after_rst_pc", pc_out, 0);
        applyStimulus(1'b0, 1'b1, 2'd3, 2'd0, 2'd1, 5'b00000, 2'd1, 2'd1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
